input_line_port: RTL and testbench
==================================

// Module: input_line_port
// PURPOSE
//  Input-side counterpart of the processor's outputLine/outputLineWrite path: produces the word the
//  processor reads on inputLine. Samples switch word on a debounced pushbutton press, holds it with a
//  valid flag until the processor consumes it with a one-cycle read strobe. Sits in top_level between SW/KEY and the core.
// PARAMETERS
//  WIDTH            16      data word width (SW[15:0])
//  DEBOUNCE_CYCLES  500000  clock cycles key must be stable to be accepted (10 ms @ 50 MHz)
//  CNT_W            20      debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  doubleClk       in   1      single clock, all state on rising edge
//  rst             in   1      asynchronous, active-high reset
//  sw              in   WIDTH  raw switch word, asynchronous to doubleClk
//  key_n           in   1      raw pushbutton, active-low (pressed = 0), bouncing
//  inputLine       out  WIDTH  captured word; stable while inputLineValid=1
//  inputLineValid  out  1      captured word pending, not yet read
//  inputLineRead   in   1      processor consume strobe; effective only when inputLineValid=1
//  overrun         out  1      sticky: a press arrived while a word was still pending
// BEHAVIOUR
//  Reset (async, any time incl. mid-debounce): inputLine=0, inputLineValid=0, overrun=0,
//   FSM=IDLE, counter=0, synchronisers preset to key_n=1 (released), sw=0.
//  Sync: sw and key_n each pass 2 flops; only synchronised copies used downstream.
//  Debounce FSM on synced key (k):
//   IDLE        : k=0 -> WAIT_PRESS, cnt=0
//   WAIT_PRESS  : k=1 -> IDLE; else cnt++; cnt==DEBOUNCE_CYCLES-1 -> HELD, emit press pulse (1 cycle)
//   HELD        : k=1 -> WAIT_RELEASE, cnt=0
//   WAIT_RELEASE: k=0 -> HELD; else cnt++; cnt==DEBOUNCE_CYCLES-1 -> IDLE
//   Exactly one press pulse per accepted press; holding key never repeats.
//  Latency: press pulse asserted DEBOUNCE_CYCLES cycles after synced k first low (+2 sync cycles from pin);
//   inputLine/inputLineValid update on the edge after the pulse.
//  Capture/consume (per cycle, pulse p, read r = inputLineRead & inputLineValid):
//   p=1, valid=0        : inputLine <= synced sw, valid <= 1
//   p=1, valid=1, r=1   : inputLine <= synced sw, valid stays 1 (old word consumed, new captured)
//   p=1, valid=1, r=0   : word NOT overwritten, overrun <= 1, press dropped
//   p=0, r=1            : valid <= 0, inputLine keeps last value
//   inputLineRead while valid=0: ignored, no state change.
//  overrun clears only on rst.
//  sw changes after capture never alter inputLine.
// STRUCTURE
//  Shared package: debounce FSM state encoding (IDLE=0, WAIT_PRESS=1, HELD=2, WAIT_RELEASE=3),
//   default DEBOUNCE_CYCLES constant for 50 MHz board clock.
//  One sub-module: key_debounce (sync + FSM + counter, outputs press pulse); top holds sync for sw,
//   capture register, valid, overrun.
// TESTING  (DEBOUNCE_CYCLES=4 for simulation)
//  1 rst pulsed mid-WAIT_PRESS -> all outputs 0 immediately, no pulse after release of rst with key_n=1.
//  2 sw=16'h1234, key_n low 10 cycles with 3 bounces of 1-2 cycles first -> exactly one capture,
//    inputLine=16'h1234, valid=1; no second capture while held.
//  3 valid=1 with 16'h1234, sw=16'hBEEF, second press, read=0 -> inputLine stays 16'h1234, overrun=1.
//  4 valid=1 (16'h1234), second press (sw=16'h00FF) with inputLineRead=1 on pulse cycle
//    -> inputLine=16'h00FF, valid=1, overrun=0.
//  5 inputLineRead=1 for 1 cycle with valid=1 -> valid=0 next edge, inputLine unchanged;
//    read with valid=0 -> no change.
//  6 key bounce on release (k toggles 1/0 every 2 cycles) -> stays HELD/WAIT_RELEASE, no extra pulse.

Source files
------------

// File: rtl/input_line_port_pkg.sv
// Shared definitions for the input line port: debounce FSM encoding and board defaults.
package input_line_port_pkg;

    localparam int unsigned WIDTH_DEFAULT           = 16;
    // 10 ms at the 50 MHz board clock
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int unsigned CNT_W_DEFAULT           = 20;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_HELD         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } deb_state_e;

endpackage : input_line_port_pkg

// File: rtl/input_line_port_if.sv
// Processor-facing bus of the input line port.
//   inputLine      : captured word (port -> processor)
//   inputLineValid : word pending  (port -> processor)
//   inputLineRead  : consume strobe (processor -> port)
//   overrun        : sticky press-dropped flag (port -> processor)
interface input_line_port_if
    import input_line_port_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);

    logic [WIDTH-1:0] inputLine;
    logic             inputLineValid;
    logic             inputLineRead;
    logic             overrun;

    // Port side
    modport master (
        output inputLine,
        output inputLineValid,
        output overrun,
        input  inputLineRead
    );

    // Processor side
    modport slave (
        input  inputLine,
        input  inputLineValid,
        input  overrun,
        output inputLineRead
    );

endinterface : input_line_port_if

// File: rtl/input_line_port_key_debounce.sv
// Key debouncer: two-flop synchroniser on the active-low pushbutton, then a
// press/release debounce FSM. Emits a single-cycle press_c for every accepted press.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   key_n    : raw pushbutton, active-low, bouncing
//   press_c  : one-cycle accepted-press pulse (combinational from state)
module input_line_port_key_debounce
    import input_line_port_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press_c
);

    logic             key_meta_q;
    logic             key_sync_q;
    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_last;

    // Synchroniser presets to "released" so reset never looks like a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_last = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Next-state, counter and press pulse
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!key_sync_q) begin
                    state_d = ST_WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_PRESS: begin
                if (key_sync_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_last) begin
                    state_d = ST_HELD;
                    press_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (key_sync_q) begin
                    state_d = ST_WAIT_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!key_sync_q) begin
                    state_d = ST_HELD;
                end else if (cnt_last) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule : input_line_port_key_debounce

// File: rtl/input_line_port.sv
// Input line port: captures the switch word on a debounced key press and holds it
// with a valid flag until the processor consumes it.
// Ports:
//   doubleClk : single clock, all state on rising edge
//   rst       : asynchronous active-high reset
//   sw        : raw switch word (asynchronous)
//   key_n     : raw pushbutton, active-low
//   cpu       : processor bus (inputLine, inputLineValid, inputLineRead, overrun)
module input_line_port
    import input_line_port_pkg::*;
#(
    parameter int unsigned WIDTH           = WIDTH_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic              doubleClk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  sw,
    input  logic              key_n,
    input_line_port_if.master cpu
);

    logic [WIDTH-1:0] sw_meta_q;
    logic [WIDTH-1:0] sw_sync_q;
    logic             press_c;
    logic             read_c;
    logic [WIDTH-1:0] line_q;
    logic [WIDTH-1:0] line_d;
    logic             valid_q;
    logic             valid_d;
    logic             overrun_q;
    logic             overrun_d;

    input_line_port_key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key_debounce (
        .clk     (doubleClk),
        .rst     (rst),
        .key_n   (key_n),
        .press_c (press_c)
    );

    // Switch word synchroniser
    always_ff @(posedge doubleClk or posedge rst) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Capture, valid and overrun registers
    always_ff @(posedge doubleClk or posedge rst) begin
        if (rst) begin
            line_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            line_q    <= line_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // A read only counts against a pending word
    assign read_c = cpu.inputLineRead & valid_q;

    // A press refills the slot if it is empty or being emptied this cycle,
    // otherwise the press is dropped and flagged.
    always_comb begin
        line_d    = line_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (press_c) begin
            if (!valid_q || read_c) begin
                line_d  = sw_sync_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (read_c) begin
            valid_d = 1'b0;
        end
    end

    assign cpu.inputLine      = line_q;
    assign cpu.inputLineValid = valid_q;
    assign cpu.overrun        = overrun_q;

endmodule : input_line_port

// File: tb/tb_input_line_port.sv
// Testbench for input_line_port with a short debounce window.
module tb_input_line_port;

    localparam int unsigned W  = 16;
    localparam int unsigned DC = 4;

    logic          doubleClk;
    logic          rst;
    logic [W-1:0]  sw;
    logic          key_n;

    int checks   = 0;
    int failures = 0;

    input_line_port_if #(.WIDTH(W)) cpu_if ();

    input_line_port #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (3)
    ) dut (
        .doubleClk (doubleClk),
        .rst       (rst),
        .sw        (sw),
        .key_n     (key_n),
        .cpu       (cpu_if)
    );

    initial begin
        doubleClk = 1'b0;
        forever #5 doubleClk = ~doubleClk;
    end

    // Reference model: a press is accepted after DC+1 consecutive low samples of the
    // synchronised key while released; a release after DC+1 consecutive high samples.
    // The synchronised view lags the pin by two clock edges.
    logic [W-1:0] m_line  = '0;
    logic         m_valid = 1'b0;
    logic         m_ovr   = 1'b0;
    logic         m_pressed;
    int           m_run;
    logic         kd1, kd2;
    logic [W-1:0] swd1, swd2;
    int           m_presses = 0;

    always @(posedge doubleClk or posedge rst) begin
        logic         k_seen;
        logic [W-1:0] sw_seen;
        logic         p;
        logic         rd;
        if (rst) begin
            kd1 = 1'b1; kd2 = 1'b1; swd1 = '0; swd2 = '0;
            m_pressed = 1'b0; m_run = 0;
            m_line = '0; m_valid = 1'b0; m_ovr = 1'b0;
        end else begin
            k_seen  = kd2;
            sw_seen = swd2;
            kd2 = kd1;  kd1 = key_n;
            swd2 = swd1; swd1 = sw;
            p = 1'b0;
            if (k_seen == m_pressed) begin
                m_run = m_run + 1;
                if (m_run == DC + 1) begin
                    p         = !m_pressed;
                    m_pressed = !m_pressed;
                    m_run     = 0;
                end
            end else begin
                m_run = 0;
            end
            if (p) m_presses++;
            rd = cpu_if.inputLineRead & m_valid;
            if (p) begin
                if (!m_valid || rd) begin
                    m_line  = sw_seen;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (rd) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare all outputs against the model
    task automatic cycle();
        @(negedge doubleClk);
        check("line",    cpu_if.inputLine, m_line);
        check("valid",   W'(cpu_if.inputLineValid), W'(m_valid));
        check("overrun", W'(cpu_if.overrun), W'(m_ovr));
    endtask

    task automatic do_press(input logic [W-1:0] w, input int bounces, input int hold,
                            input int rel_bounces);
        sw = w;
        cycle();
        for (int b = 0; b < bounces; b++) begin
            key_n = 1'b0;
            repeat ($urandom_range(1, 2)) cycle();
            key_n = 1'b1;
            repeat ($urandom_range(1, 2)) cycle();
        end
        key_n = 1'b0;
        repeat (hold) cycle();
        sw = W'($urandom);
        for (int b = 0; b < rel_bounces; b++) begin
            key_n = 1'b1;
            repeat (2) cycle();
            key_n = 1'b0;
            repeat (2) cycle();
        end
        key_n = 1'b1;
        repeat (10) cycle();
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        key_n = 1'b1;
        #1;
        check("rst_line",    cpu_if.inputLine, W'(0));
        check("rst_valid",   W'(cpu_if.inputLineValid), W'(0));
        check("rst_overrun", W'(cpu_if.overrun), W'(0));
        @(negedge doubleClk);
        rst = 1'b0;
    endtask

    initial begin
        int n0;
        rst   = 1'b1;
        sw    = '0;
        key_n = 1'b1;
        cpu_if.inputLineRead = 1'b0;
        repeat (2) @(negedge doubleClk);
        rst = 1'b0;
        check("reset_line",  cpu_if.inputLine, W'(0));
        check("reset_valid", W'(cpu_if.inputLineValid), W'(0));
        repeat (3) cycle();

        // Bouncy press captures exactly once, holding does not repeat
        n0 = m_presses;
        do_press(16'h1234, 3, 10, 0);
        check("cap_line",  cpu_if.inputLine, 16'h1234);
        check("cap_valid", W'(cpu_if.inputLineValid), W'(1));
        check("cap_count", W'(m_presses - n0), W'(1));

        // Second press while pending and unread: dropped, overrun set
        do_press(16'hBEEF, 0, 10, 0);
        check("ovr_line", cpu_if.inputLine, 16'h1234);
        check("ovr_flag", W'(cpu_if.overrun), W'(1));

        // Reset in the middle of a press debounce
        sw    = 16'h5555;
        key_n = 1'b0;
        repeat (4) cycle();
        pulse_reset();
        repeat (12) cycle();
        check("post_rst_valid", W'(cpu_if.inputLineValid), W'(0));

        // Press with read strobe on the pulse cycle: consume and refill
        do_press(16'h1234, 0, 10, 0);
        sw = 16'h00FF;
        cycle();
        key_n = 1'b0;
        repeat (6) cycle();
        cpu_if.inputLineRead = 1'b1;
        cycle();
        cpu_if.inputLineRead = 1'b0;
        repeat (6) cycle();
        check("swap_line",    cpu_if.inputLine, 16'h00FF);
        check("swap_valid",   W'(cpu_if.inputLineValid), W'(1));
        check("swap_overrun", W'(cpu_if.overrun), W'(0));
        key_n = 1'b1;
        repeat (10) cycle();

        // Single read clears valid; a read while empty changes nothing
        cpu_if.inputLineRead = 1'b1;
        cycle();
        cpu_if.inputLineRead = 1'b0;
        cycle();
        check("read_valid", W'(cpu_if.inputLineValid), W'(0));
        check("read_line",  cpu_if.inputLine, 16'h00FF);
        cpu_if.inputLineRead = 1'b1;
        repeat (2) cycle();
        cpu_if.inputLineRead = 1'b0;
        cycle();
        check("idle_read_line",  cpu_if.inputLine, 16'h00FF);
        check("idle_read_valid", W'(cpu_if.inputLineValid), W'(0));

        // Release bounce must not produce a second press
        n0 = m_presses;
        do_press(16'hA5A5, 0, 10, 3);
        check("relb_count", W'(m_presses - n0), W'(1));
        check("relb_line",  cpu_if.inputLine, 16'hA5A5);

        // Randomised presses and reads
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                cpu_if.inputLineRead = 1'b1;
                cycle();
                cpu_if.inputLineRead = 1'b0;
            end
            do_press(W'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(8, 14)),
                     int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_input_line_port
